snoop_bus_ctrl: RTL and testbench
=================================

// Module: snoop_bus_ctrl
// PURPOSE
// Parametrised successor to the 4-core coherency bus: N-core round-robin arbitration
// with a valid/ready request handshake and a latched broadcast. It collects per-core
// snoop responses with shared/dirty aggregation and timeout, then reports one completion.
// Sits between the per-core cache controllers and the shared snoop network.
// PARAMETERS
// NUM_CORES       4   requesting/snooping cores, >=2, any integer (need not be power of 2)
// ADDR_WIDTH      64  request address width
// TYPE_WIDTH      2   bus transaction type width (encodings in coh_bus_pkg)
// TIMEOUT_CYCLES  16  max COLLECT cycles before forced completion; 0 disables timeout
// ID_W            localparam = $clog2(NUM_CORES)
// PORTS
// clk                clk  in   1                     clock, all logic on posedge
// rst_n              in   1                          async active-low reset
// core_req_valid     in   NUM_CORES                  request pending per core; held until ready
// core_req_ready     out  NUM_CORES                  one-hot accept; transfer on valid&&ready
// core_req_type      in   NUM_CORES x TYPE_WIDTH     per-core transaction type
// core_req_addr      in   NUM_CORES x ADDR_WIDTH     per-core address
// bus_valid          out  1                          broadcast strobe, exactly one cycle per txn
// bus_addr           out  ADDR_WIDTH                 latched address of accepted request
// bus_type           out  TYPE_WIDTH                 latched type
// bus_src_id         out  ID_W                       originating core
// snoop_resp_valid   in   NUM_CORES                  per-core snoop response strobe
// snoop_resp_shared  in   NUM_CORES                  responder holds line (S/E/O)
// snoop_resp_dirty   in   NUM_CORES                  responder holds line dirty (M/O)
// done_valid         out  1                          one-cycle completion pulse
// done_src_id        out  ID_W                       core whose transaction completed
// done_shared        out  1                          OR of shared over counted responses
// done_dirty         out  1                          OR of dirty over counted responses
// done_timeout       out  1                          completion forced by timeout
// BEHAVIOUR
// - Reset: state IDLE, rr_ptr=0, pending=0, timer=0; all outputs 0. Reset mid-transaction abandons it silently.
// - Clock/reset: one clock; reset is asynchronous and active-low (rst_n), as decided.
// - FSM IDLE->BROADCAST->COLLECT->DONE->IDLE.
// - IDLE: if |core_req_valid, winner = first valid at or after rr_ptr, wrapping modulo NUM_CORES.
//   core_req_ready[winner]=1 combinationally in that cycle only. Latch addr, type, src. Go to BROADCAST.
//   core_req_ready=0 in all other states.
// - BROADCAST: bus_valid=1 for one cycle; pending = all cores except src; timer=0. Go to COLLECT.
//   bus_addr/bus_type/bus_src_id are registered and stable from BROADCAST to the next accept.
// - Response sampling covers BROADCAST and COLLECT cycles. A response counts only if its pending bit is set.
//   A counted response clears that bit and ORs its shared/dirty into the accumulators.
//   Responses from src, duplicates, and responses in IDLE/DONE are ignored.
// - COLLECT: go to DONE in the cycle pending (after this cycle's clears) is empty.
//   Otherwise timer++; if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1, go to DONE with timeout flag set.
//   Simultaneous last response and timeout: completion without timeout.
// - DONE: done_valid=1 with src/shared/dirty/timeout for one cycle; rr_ptr=(src+1) mod NUM_CORES.
//   Accumulators clear; go to IDLE.
// - Latency: accept at T, bus_valid T+1, earliest done_valid T+3, next accept T+4.
// - Fairness: a continuously valid core is granted within NUM_CORES transactions.
// - Assert: core_req_ready is one-hot or zero; bus_valid never on two consecutive cycles.
// STRUCTURE
// - coh_bus_pkg: bus_state_t enum; bus type encodings BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_WB=3.
//   Also holds the snoop response struct.
// - Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot grant and binary id.
//   Purely combinational, reused by memory-side arbitration.
// - Top owns FSM, request latch, pending mask, accumulators and timeout counter.
// TESTING
// - Single req core2, cores 0,1,3 respond at T+2 -> bus_src_id=2, done_valid at T+3, rr_ptr=3.
// - All 4 valid continuously, all respond immediately -> grant order 0,1,2,3,0.
//   Each core gets exactly one bus_valid per round.
// - Req core0; core1 shared, core3 dirty, core2 silent, TIMEOUT=16 -> done_timeout=1, shared=1, dirty=1.
//   done_valid 16 cycles after bus_valid.
// - Src core1 asserts snoop_resp_valid+dirty; core0 responds twice -> done_dirty=0.
//   Done waits for cores 0,2,3 (each counted once).
// - rst_n low during COLLECT -> outputs 0 immediately; after release, first grant comes from core0.
// - NUM_CORES=3, TIMEOUT=0, req core2 -> next grant wraps to core0.
//   No timeout fires with a withheld response over 100 cycles.

Source files
------------

// File: rtl/coh_bus_pkg.sv
// Shared types for the coherency snoop bus: controller states, transaction
// type encodings and the per-transaction snoop response aggregate.
package coh_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BROADCAST = 2'd1,
    ST_COLLECT   = 2'd2,
    ST_DONE      = 2'd3
  } bus_state_t;

  localparam logic [1:0] BUS_RD   = 2'd0;
  localparam logic [1:0] BUS_RDX  = 2'd1;
  localparam logic [1:0] BUS_UPGR = 2'd2;
  localparam logic [1:0] BUS_WB   = 2'd3;

  typedef struct packed {
    logic shared;
    logic dirty;
  } snoop_resp_t;

  // Folds one cycle's worth of counted responses into the running aggregate.
  function automatic snoop_resp_t merge_resp(input snoop_resp_t acc, input logic any_shared,
                                             input logic any_dirty);
    snoop_resp_t res;
    res.shared = acc.shared | any_shared;
    res.dirty  = acc.dirty | any_dirty;
    return res;
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo N (N need not be a power of two).
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id
);

  logic            found_s;
  logic [ID_W-1:0] idx_s;

  // Priority scan starting at ptr.
  always_comb begin
    grant   = '0;
    id      = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = ID_W'((int'(ptr) + k) % N);
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        id           = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// N-core snoop bus controller: round-robin request accept, one-cycle broadcast,
// pending-mask response collection with shared/dirty aggregation and timeout.
module snoop_bus_ctrl
  import coh_bus_pkg::*;
#(
  parameter  int NUM_CORES      = 4,
  parameter  int ADDR_WIDTH     = 64,
  parameter  int TYPE_WIDTH     = 2,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int ID_W           = $clog2(NUM_CORES)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CORES-1:0]                  core_req_valid,
  output logic [NUM_CORES-1:0]                  core_req_ready,
  input  logic [NUM_CORES-1:0][TYPE_WIDTH-1:0]  core_req_type,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  core_req_addr,
  output logic                                  bus_valid,
  output logic [ADDR_WIDTH-1:0]                 bus_addr,
  output logic [TYPE_WIDTH-1:0]                 bus_type,
  output logic [ID_W-1:0]                       bus_src_id,
  input  logic [NUM_CORES-1:0]                  snoop_resp_valid,
  input  logic [NUM_CORES-1:0]                  snoop_resp_shared,
  input  logic [NUM_CORES-1:0]                  snoop_resp_dirty,
  output logic                                  done_valid,
  output logic [ID_W-1:0]                       done_src_id,
  output logic                                  done_shared,
  output logic                                  done_dirty,
  output logic                                  done_timeout
);

  localparam int              TMR_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES) + 1;
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES-1){1'b0}}, 1'b1};

  bus_state_t           state_r, state_s;
  logic [ID_W-1:0]      rr_ptr_r, win_id_s;
  logic [NUM_CORES-1:0] win_grant_s, pending_r, pending_s, mask_s, counted_s;
  snoop_resp_t          acc_r, acc_s;
  logic [TMR_W-1:0]     timer_r, timer_s;
  logic                 accept_s, timeout_s;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req   (core_req_valid),
    .ptr   (rr_ptr_r),
    .grant (win_grant_s),
    .id    (win_id_s)
  );

  // Response qualification: the source is excluded the moment BROADCAST starts.
  always_comb begin
    mask_s = '0;
    case (state_r)
      ST_BROADCAST: mask_s = ~(ONE_HOT0 << bus_src_id);
      ST_COLLECT:   mask_s = pending_r;
      default:      mask_s = '0;
    endcase
    counted_s = snoop_resp_valid & mask_s;
    pending_s = mask_s & ~counted_s;
    acc_s     = merge_resp(acc_r, |(counted_s & snoop_resp_shared),
                           |(counted_s & snoop_resp_dirty));
  end

  // Next-state, grant and timeout decision.
  always_comb begin
    state_s        = state_r;
    core_req_ready = '0;
    accept_s       = 1'b0;
    timeout_s      = 1'b0;
    timer_s        = timer_r;
    case (state_r)
      ST_IDLE: begin
        if (|core_req_valid) begin
          core_req_ready = win_grant_s;
          accept_s       = 1'b1;
          state_s        = ST_BROADCAST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BROADCAST: begin
        timer_s = '0;
        state_s = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (pending_s == '0) begin
          state_s = ST_DONE;
        end else if (TMO_EN) begin
          timer_s = timer_r + TMR_W'(1);
          if (timer_s >= TMR_LAST) begin
            state_s   = ST_DONE;
            timeout_s = 1'b1;
          end else begin
            state_s = ST_COLLECT;
          end
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer, pending mask, accumulators, timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      pending_r <= '0;
      acc_r     <= '0;
      timer_r   <= '0;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      timer_r   <= timer_s;
      acc_r     <= (state_r == ST_BROADCAST || state_r == ST_COLLECT) ? acc_s : '0;
      if (state_r == ST_DONE) begin
        rr_ptr_r <= (bus_src_id == ID_W'(NUM_CORES - 1)) ? '0 : bus_src_id + ID_W'(1);
      end
    end
  end

  // Registered bus and completion outputs; done fields are zero outside the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid    <= 1'b0;
      bus_addr     <= '0;
      bus_type     <= '0;
      bus_src_id   <= '0;
      done_valid   <= 1'b0;
      done_src_id  <= '0;
      done_shared  <= 1'b0;
      done_dirty   <= 1'b0;
      done_timeout <= 1'b0;
    end else begin
      if (accept_s) begin
        bus_addr   <= core_req_addr[win_id_s];
        bus_type   <= core_req_type[win_id_s];
        bus_src_id <= win_id_s;
      end
      bus_valid    <= (state_s == ST_BROADCAST);
      done_valid   <= (state_s == ST_DONE);
      done_src_id  <= (state_s == ST_DONE) ? bus_src_id : '0;
      done_shared  <= (state_s == ST_DONE) & acc_s.shared;
      done_dirty   <= (state_s == ST_DONE) & acc_s.dirty;
      done_timeout <= timeout_s;
    end
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl: a 4-core/timeout-16 instance for the main
// scenarios and a 3-core/no-timeout instance for wrap and no-timeout behaviour.
module tb_snoop_bus_ctrl;
  import coh_bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]          core_req_valid, core_req_ready;
  logic [N-1:0][TW-1:0]  core_req_type;
  logic [N-1:0][AW-1:0]  core_req_addr;
  logic                  bus_valid, done_valid, done_shared, done_dirty, done_timeout;
  logic [AW-1:0]         bus_addr;
  logic [TW-1:0]         bus_type;
  logic [1:0]            bus_src_id, done_src_id;
  logic [N-1:0]          snoop_resp_valid, snoop_resp_shared, snoop_resp_dirty;

  logic [2:0]            req_valid3, req_ready3, resp_valid3, resp_shared3, resp_dirty3;
  logic [2:0][TW-1:0]    req_type3;
  logic [2:0][AW-1:0]    req_addr3;
  logic                  bus_valid3, done_valid3, done_shared3, done_dirty3, done_timeout3;
  logic [AW-1:0]         bus_addr3;
  logic [TW-1:0]         bus_type3;
  logic [1:0]            bus_src_id3, done_src_id3;

  snoop_bus_ctrl #(.NUM_CORES(4), .ADDR_WIDTH(AW), .TYPE_WIDTH(TW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_type(core_req_type), .core_req_addr(core_req_addr),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_type(bus_type), .bus_src_id(bus_src_id),
    .snoop_resp_valid(snoop_resp_valid), .snoop_resp_shared(snoop_resp_shared),
    .snoop_resp_dirty(snoop_resp_dirty),
    .done_valid(done_valid), .done_src_id(done_src_id), .done_shared(done_shared),
    .done_dirty(done_dirty), .done_timeout(done_timeout)
  );

  snoop_bus_ctrl #(.NUM_CORES(3), .ADDR_WIDTH(AW), .TYPE_WIDTH(TW), .TIMEOUT_CYCLES(0)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(req_valid3), .core_req_ready(req_ready3),
    .core_req_type(req_type3), .core_req_addr(req_addr3),
    .bus_valid(bus_valid3), .bus_addr(bus_addr3), .bus_type(bus_type3), .bus_src_id(bus_src_id3),
    .snoop_resp_valid(resp_valid3), .snoop_resp_shared(resp_shared3),
    .snoop_resp_dirty(resp_dirty3),
    .done_valid(done_valid3), .done_src_id(done_src_id3), .done_shared(done_shared3),
    .done_dirty(done_dirty3), .done_timeout(done_timeout3)
  );

  typedef struct { int src; logic [AW-1:0] addr; logic [TW-1:0] typ; int cyc; } bus_exp_t;
  typedef struct { int src; logic sh; logic dt; logic to; int cyc; } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  bus_exp_t  be;
  done_exp_t de;
  logic      prev_bv = 1'b0;
  int        total = 0;
  int        bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive a request set, check the expected one-hot grant, push the broadcast expectation.
  task automatic accept_one(input logic [N-1:0] vmask, input int core, input logic [TW-1:0] typ,
                            output int t);
    @(negedge clk);
    core_req_valid      = vmask;
    core_req_type[core] = typ;
    #1;
    check_eq("accept_ready", core_req_ready, 64'(4'b0001 << core));
    t = cyc;
    bus_q.push_back('{core, core_req_addr[core], typ, cyc + 1});
  endtask

  // Scoreboard side: pop and compare whenever the DUT broadcasts or completes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_valid) begin
        check_eq("bus_valid_b2b", prev_bv, 0);
        if (bus_q.size() == 0) begin
          check_eq("bus_unexpected", bus_q.size(), 1);
        end else begin
          be = bus_q.pop_front();
          check_eq("bus_src_id", bus_src_id, be.src);
          check_eq("bus_addr", bus_addr, be.addr);
          check_eq("bus_type", bus_type, be.typ);
          check_eq("bus_cycle", cyc, be.cyc);
        end
      end
      if (done_valid) begin
        if (done_q.size() == 0) begin
          check_eq("done_unexpected", done_q.size(), 1);
        end else begin
          de = done_q.pop_front();
          check_eq("done_src_id", done_src_id, de.src);
          check_eq("done_shared", done_shared, de.sh);
          check_eq("done_dirty", done_dirty, de.dt);
          check_eq("done_timeout", done_timeout, de.to);
          check_eq("done_cycle", cyc, de.cyc);
        end
      end
    end
    prev_bv <= bus_valid;
  end

  initial begin
    int t, t_prev, g, gid, last_t, d3;
    int order [5] = '{0, 1, 2, 3, 0};

    core_req_valid = '0; snoop_resp_valid = '0; snoop_resp_shared = '0; snoop_resp_dirty = '0;
    req_valid3 = '0; resp_valid3 = '0; resp_shared3 = '0; resp_dirty3 = '0;
    for (int i = 0; i < N; i++) begin
      core_req_addr[i] = {32'hC0DE_0000, 32'(i * 16 + 4)};
      core_req_type[i] = TW'(i);
    end
    for (int i = 0; i < 3; i++) begin
      req_addr3[i] = {32'hBEEF_0000, 32'(i)};
      req_type3[i] = BUS_RD;
    end

    repeat (3) @(negedge clk);
    check_eq("rst_bus_valid", bus_valid, 0);
    check_eq("rst_done_valid", done_valid, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_src", bus_src_id, 0);
    check_eq("rst_ready", core_req_ready, 0);
    check_eq("rst_bus_valid3", bus_valid3, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request from core2, cores 0,1,3 respond in the first COLLECT cycle.
    accept_one(4'b0100, 2, BUS_RDX, t);
    done_q.push_back('{2, 1'b0, 1'b0, 1'b0, t + 3});
    @(negedge clk); core_req_valid = '0;
    @(negedge clk); snoop_resp_valid = 4'b1011;
    @(negedge clk); snoop_resp_valid = '0;
    t_prev = t;

    // Pointer now 3: cores 0 and 3 valid -> core3 wins; accept right at T+4.
    accept_one(4'b1001, 3, BUS_RD, t);
    check_eq("next_accept_gap", t - t_prev, 4);
    done_q.push_back('{3, 1'b1, 1'b0, 1'b0, t + 3});
    @(negedge clk);
    core_req_valid = '0; snoop_resp_valid = 4'b1111; snoop_resp_shared = 4'b0001;
    @(negedge clk); snoop_resp_valid = '0; snoop_resp_shared = '0;
    repeat (3) @(negedge clk);

    // Timeout: core2 never answers; done arrives 16 cycles after the broadcast.
    accept_one(4'b0001, 0, BUS_UPGR, t);
    done_q.push_back('{0, 1'b1, 1'b1, 1'b1, t + 17});
    @(negedge clk); core_req_valid = '0;
    @(negedge clk);
    snoop_resp_valid = 4'b1010; snoop_resp_shared = 4'b0010; snoop_resp_dirty = 4'b1000;
    @(negedge clk); snoop_resp_valid = '0; snoop_resp_shared = '0; snoop_resp_dirty = '0;
    repeat (20) @(negedge clk);

    // Source response and duplicate dirty response are ignored.
    accept_one(4'b0010, 1, BUS_WB, t);
    done_q.push_back('{1, 1'b0, 1'b0, 1'b0, t + 5});
    @(negedge clk); core_req_valid = '0; snoop_resp_valid = 4'b0011; snoop_resp_dirty = 4'b0010;
    @(negedge clk); snoop_resp_valid = 4'b0001; snoop_resp_dirty = 4'b0001;
    @(negedge clk); snoop_resp_valid = 4'b0100; snoop_resp_dirty = '0;
    @(negedge clk); snoop_resp_valid = 4'b1000;
    @(negedge clk); snoop_resp_valid = '0;
    repeat (3) @(negedge clk);

    // Reset in the middle of COLLECT abandons the transaction.
    accept_one(4'b1000, 3, BUS_RD, t);
    @(negedge clk); core_req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_bus_valid", bus_valid, 0);
    check_eq("mid_rst_bus_addr", bus_addr, 0);
    check_eq("mid_rst_bus_src", bus_src_id, 0);
    check_eq("mid_rst_bus_type", bus_type, 0);
    check_eq("mid_rst_done", {done_valid, done_timeout, done_shared, done_dirty}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All cores continuously valid and responding: grants 0,1,2,3,0 every 4 cycles.
    @(negedge clk);
    core_req_valid = 4'b1111; snoop_resp_valid = 4'b1111;
    snoop_resp_shared = 4'b0101; snoop_resp_dirty = 4'b1000;
    g = 0; last_t = 0;
    for (int c = 0; c < 40 && g < 5; c++) begin
      #1;
      if (core_req_ready != '0) begin
        check_eq("ready_onehot", $onehot(core_req_ready), 1);
        gid = 0;
        for (int i = 0; i < N; i++) if (core_req_ready[i]) gid = i;
        check_eq("rr_order", gid, order[g]);
        if (g > 0) check_eq("rr_accept_gap", cyc - last_t, 4);
        bus_q.push_back('{order[g], core_req_addr[order[g]], core_req_type[order[g]], cyc + 1});
        done_q.push_back('{order[g], 1'b1, (order[g] != 3), 1'b0, cyc + 3});
        last_t = cyc;
        g++;
      end
      @(negedge clk);
    end
    core_req_valid = '0;
    check_eq("rr_grants", g, 5);
    repeat (6) @(negedge clk);
    snoop_resp_valid = '0; snoop_resp_shared = '0; snoop_resp_dirty = '0;
    repeat (2) @(negedge clk);

    // Three cores, no timeout: withheld response stalls indefinitely, then wrap to core0.
    @(negedge clk); req_valid3 = 3'b100;
    #1; check_eq("nc3_ready", req_ready3, 3'b100);
    @(negedge clk); req_valid3 = '0; resp_valid3 = 3'b001;
    check_eq("nc3_bus_valid", bus_valid3, 1);
    check_eq("nc3_bus_src", bus_src_id3, 2);
    @(negedge clk); resp_valid3 = '0;
    d3 = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_valid3) d3++;
    end
    check_eq("nc3_no_timeout", d3, 0);
    resp_valid3 = 3'b010;
    @(negedge clk); resp_valid3 = '0;
    #1;
    check_eq("nc3_done_valid", done_valid3, 1);
    check_eq("nc3_done_src", done_src_id3, 2);
    check_eq("nc3_done_timeout", done_timeout3, 0);
    repeat (2) @(negedge clk);
    req_valid3 = 3'b111;
    #1; check_eq("nc3_wrap_grant", req_ready3, 3'b001);
    @(negedge clk); req_valid3 = '0;

    repeat (4) @(negedge clk);
    check_eq("bus_q_drained", bus_q.size(), 0);
    check_eq("done_q_drained", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
